// File: rtl/hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO sequencer: state encoding, operation select codes, default timeout.
// No logic of its own; latency not applicable.
// No flow control of its own; consumers decide backpressure.
package hilo_ctrl_pkg;

  // Default WAIT budget: the multiplier needs 32 iterations plus some margin.
  localparam int TIMEOUT_DEF = 40;

  // OpSel encoding from the control unit.
  localparam logic OPSEL_MULT = 1'b0;
  localparam logic OPSEL_DIV  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MSTART = 3'd1,
    S_MWAIT  = 3'd2,
    S_DSTART = 3'd3,
    S_DWAIT  = 3'd4,
    S_COMMIT = 3'd5,
    S_DZERO  = 3'd6
  } state_t;

  // Counter width able to hold LIMIT-1 with one spare bit of headroom.
  function automatic int timer_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/hilo_ctrl_cycle_timer.sv
// Up-counter with synchronous clear and enable; expire flags count == LIMIT-1.
// expire is combinational from the registered count (zero added latency).
// No backpressure; the owner stops enabling it once it leaves the wait state.
module cycle_timer
  import hilo_ctrl_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEF,
  parameter int WIDTH = timer_width(LIMIT)
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [WIDTH-1:0] count;

  // Count register: clear wins over enable so a fresh wait always starts at 0.
  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign expire = (count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/hilo_ctrl.sv
// Sequences MULT/DIV through external units and owns the architectural HI/LO registers.
// MULT/DIV: start pulse one cycle after OpStart, Done one cycle after the unit's stop; MTHI/MTLO take effect next edge.
// Busy stalls the pipeline from the accepting IDLE cycle until the op retires; requests while Busy are dropped.
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        OpStart,
  input  logic        OpSel,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        MTHI,
  input  logic        MTLO,
  input  logic [31:0] WrData,
  input  logic        MultStop,
  input  logic [31:0] MultHI,
  input  logic [31:0] MultLO,
  input  logic        DivStop,
  input  logic [31:0] DivHI,
  input  logic [31:0] DivLO,
  output logic        MultStart,
  output logic        DivStart,
  output logic [31:0] OpA,
  output logic [31:0] OpB,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero,
  output logic        Timeout,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  state_t state;
  state_t state_nxt;

  logic timer_clr;
  logic timer_en;
  logic expire;

  logic accept;
  logic mt_ok;
  logic mult_hit;
  logic div_hit;

  assign accept   = (state == S_IDLE) && OpStart;
  // Register moves only land in a quiet IDLE cycle so they never race an op.
  assign mt_ok    = (state == S_IDLE) && !OpStart;
  // Stops only count from the unit we are actually waiting on.
  assign mult_hit = (state == S_MWAIT) && MultStop;
  assign div_hit  = (state == S_DWAIT) && DivStop;

  // Busy covers the accepting IDLE cycle too, so the stall starts without a bubble.
  assign Busy = (state != S_IDLE) || OpStart;

  cycle_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .Clock  (Clock),
    .Reset  (Reset),
    .clear  (timer_clr),
    .enable (timer_en),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and pulse outputs; a stop arriving on the expiry cycle still commits.
  always_comb begin
    state_nxt = state;
    MultStart = 1'b0;
    DivStart  = 1'b0;
    Done      = 1'b0;
    DivZero   = 1'b0;
    Timeout   = 1'b0;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    case (state)
      S_IDLE: begin
        if (OpStart) begin
          if (OpSel == OPSEL_MULT) begin
            state_nxt = S_MSTART;
          end else if (SrcB != '0) begin
            state_nxt = S_DSTART;
          end else begin
            state_nxt = S_DZERO;
          end
        end
      end
      S_MSTART: begin
        MultStart = 1'b1;
        timer_clr = 1'b1;
        state_nxt = S_MWAIT;
      end
      S_DSTART: begin
        DivStart  = 1'b1;
        timer_clr = 1'b1;
        state_nxt = S_DWAIT;
      end
      S_MWAIT: begin
        timer_en = 1'b1;
        if (MultStop) begin
          state_nxt = S_COMMIT;
        end else if (expire) begin
          Timeout   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DWAIT: begin
        timer_en = 1'b1;
        if (DivStop) begin
          state_nxt = S_COMMIT;
        end else if (expire) begin
          Timeout   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_COMMIT: begin
        Done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_DZERO: begin
        DivZero   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand latches: captured on acceptance and held for the whole operation.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      OpA <= '0;
      OpB <= '0;
    end else if (accept) begin
      OpA <= SrcA;
      OpB <= SrcB;
    end
  end

  // HI/LO: unit results land on the stop edge so they are visible alongside Done.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      HI <= '0;
      LO <= '0;
    end else if (mult_hit) begin
      HI <= MultHI;
      LO <= MultLO;
    end else if (div_hit) begin
      HI <= DivHI;
      LO <= DivLO;
    end else if (mt_ok) begin
      if (MTHI) HI <= WrData;
      if (MTLO) LO <= WrData;
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
`timescale 1ns/1ps
module tb_hilo_ctrl;
  import hilo_ctrl_pkg::*;

  localparam int TO = 40;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        OpStart = 1'b0, OpSel = 1'b0, MTHI = 1'b0, MTLO = 1'b0;
  logic        MultStop = 1'b0, DivStop = 1'b0;
  logic [31:0] SrcA = '0, SrcB = '0, WrData = '0;
  logic [31:0] MultHI = '0, MultLO = '0, DivHI = '0, DivLO = '0;
  logic        MultStart, DivStart, Busy, Done, DivZero, Timeout;
  logic [31:0] OpA, OpB, HI, LO;

  int checks = 0;
  int fails  = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  hilo_ctrl #(.TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset), .OpStart(OpStart), .OpSel(OpSel),
    .SrcA(SrcA), .SrcB(SrcB), .MTHI(MTHI), .MTLO(MTLO), .WrData(WrData),
    .MultStop(MultStop), .MultHI(MultHI), .MultLO(MultLO),
    .DivStop(DivStop), .DivHI(DivHI), .DivLO(DivLO),
    .MultStart(MultStart), .DivStart(DivStart), .OpA(OpA), .OpB(OpB),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Timeout(Timeout),
    .HI(HI), .LO(LO)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Architectural result: signed 64-bit product, or {remainder, quotient}.
  function automatic logic [63:0] ref_result(input logic sel, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic signed [31:0] q, r;
    if (sel == OPSEL_MULT) begin
      p = $signed(a) * $signed(b);
      return p;
    end
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {r, q};
  endfunction

  // One full operation with a stub unit answering after 'delay' wait cycles (if stop_en).
  task automatic run_op(input logic sel, input logic [31:0] a, input logic [31:0] b,
                        input int delay, input bit stop_en,
                        input logic [31:0] r_hi, input logic [31:0] r_lo);
    bit dz, fired, tmo;
    dz = (sel == OPSEL_DIV) && (b == 32'd0);
    fired = 1'b0;
    step();
    SrcA = a; SrcB = b; OpSel = sel; OpStart = 1'b1;
    MTHI = 1'b1; WrData = $urandom;   // must be dropped: OpStart has priority
    @(negedge Clock);
    checks++;
    if (Busy !== 1'b1) begin fails++; $display("FAIL busy_on_accept: got %b want 1", Busy); end
    step();
    OpStart = 1'b0; MTHI = 1'b0; SrcA = ~a; SrcB = $urandom;
    @(negedge Clock);
    checks++;
    if ({MultStart, DivStart, DivZero, Busy, OpA, OpB} !== {~sel, sel & ~dz, dz, 1'b1, a, b}) begin
      fails++;
      $display("FAIL start_cycle: got ms=%b ds=%b dz=%b busy=%b opa=%h opb=%h want ms=%b ds=%b dz=%b busy=1 opa=%h opb=%h",
               MultStart, DivStart, DivZero, Busy, OpA, OpB, ~sel, sel & ~dz, dz, a, b);
    end
    if (dz) begin
      step();
      @(negedge Clock);
      checks++;
      if ({Busy, DivZero, DivStart, Done, HI, LO} !== {4'b0000, exp_hi, exp_lo}) begin
        fails++;
        $display("FAIL divzero_retire: got busy=%b dz=%b ds=%b done=%b hi=%h lo=%h want 0 0 0 0 hi=%h lo=%h",
                 Busy, DivZero, DivStart, Done, HI, LO, exp_hi, exp_lo);
      end
      return;
    end
    for (int w = 1; w <= TO; w++) begin
      step();
      MultStop = 1'b0; DivStop = 1'b0; MTHI = 1'b0; MTLO = 1'b0;
      if (stop_en && w == delay) begin
        if (sel == OPSEL_MULT) begin MultStop = 1'b1; MultHI = r_hi; MultLO = r_lo; end
        else begin DivStop = 1'b1; DivHI = r_hi; DivLO = r_lo; end
        fired = 1'b1;
      end else if (w == 2) begin
        // stray stop from the unit that was not started
        if (sel == OPSEL_MULT) begin DivStop = 1'b1; DivHI = $urandom; DivLO = $urandom; end
        else begin MultStop = 1'b1; MultHI = $urandom; MultLO = $urandom; end
      end
      if (w == 3) begin MTHI = 1'b1; MTLO = 1'b1; WrData = $urandom; end
      tmo = (w == TO) && !fired;
      @(negedge Clock);
      checks++;
      if ({MultStart, DivStart, Done, DivZero, Busy, Timeout, OpA, OpB} !== {4'b0000, 1'b1, tmo, a, b}) begin
        fails++;
        $display("FAIL wait_cycle%0d: got ms=%b ds=%b done=%b dz=%b busy=%b tmo=%b opa=%h opb=%h want 0 0 0 0 1 tmo=%b opa=%h opb=%h",
                 w, MultStart, DivStart, Done, DivZero, Busy, Timeout, OpA, OpB, tmo, a, b);
      end
      if (fired || w == TO) break;
    end
    step();
    MultStop = 1'b0; DivStop = 1'b0; MTHI = 1'b0; MTLO = 1'b0;
    if (fired) begin
      exp_hi = r_hi; exp_lo = r_lo;
      @(negedge Clock);
      checks++;
      if ({MultStart, DivStart, Done, Busy, Timeout, HI, LO} !== {4'b0011, 1'b0, exp_hi, exp_lo}) begin
        fails++;
        $display("FAIL commit: got ms=%b ds=%b done=%b busy=%b tmo=%b hi=%h lo=%h want 0 0 1 1 0 hi=%h lo=%h",
                 MultStart, DivStart, Done, Busy, Timeout, HI, LO, exp_hi, exp_lo);
      end
      step();
      @(negedge Clock);
      checks++;
      if ({Done, Busy, HI, LO} !== {2'b00, exp_hi, exp_lo}) begin
        fails++;
        $display("FAIL done_single_pulse: got done=%b busy=%b hi=%h lo=%h want 0 0 hi=%h lo=%h",
                 Done, Busy, HI, LO, exp_hi, exp_lo);
      end
    end else begin
      @(negedge Clock);
      checks++;
      if ({Busy, Timeout, Done, HI, LO} !== {3'b000, exp_hi, exp_lo}) begin
        fails++;
        $display("FAIL after_timeout: got busy=%b tmo=%b done=%b hi=%h lo=%h want 0 0 0 hi=%h lo=%h",
                 Busy, Timeout, Done, HI, LO, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step(); step();
    @(negedge Clock);
    checks++;
    if ({MultStart, DivStart, Busy, Done, DivZero, Timeout, OpA, OpB, HI, LO} !== 134'd0) begin
      fails++;
      $display("FAIL reset_state: got ms=%b ds=%b busy=%b done=%b dz=%b tmo=%b opa=%h opb=%h hi=%h lo=%h want all zero",
               MultStart, DivStart, Busy, Done, DivZero, Timeout, OpA, OpB, HI, LO);
    end
    step();
    Reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] pat [3];
    logic [1:0]  sel [3];
    pat[0] = 32'h0000_1234; sel[0] = 2'b10;
    pat[1] = 32'hDEAD_BEEF; sel[1] = 2'b01;
    pat[2] = 32'hA5A5_A5A5; sel[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      MTHI = sel[i][1]; MTLO = sel[i][0]; WrData = pat[i];
      step();
      MTHI = 1'b0; MTLO = 1'b0; WrData = $urandom;
      if (sel[i][1]) exp_hi = pat[i];
      if (sel[i][0]) exp_lo = pat[i];
      @(negedge Clock);
      checks++;
      if ({HI, LO, Busy} !== {exp_hi, exp_lo, 1'b0}) begin
        fails++;
        $display("FAIL mt_write%0d: got hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0", i, HI, LO, Busy, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic test_mult();
    run_op(OPSEL_MULT, 32'd3, 32'd5, 33, 1'b1, 32'd0, 32'd15);
    run_op(OPSEL_MULT, 32'hFFFF_FFFE, 32'd3, 12, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op(OPSEL_MULT, 32'd7, 32'd6, 1, 1'b1, 32'd0, 32'd42);
    // stop lands on the expiry cycle: stop must win
    run_op(OPSEL_MULT, 32'h0001_0000, 32'h0001_0000, TO, 1'b1, 32'd1, 32'd0);
  endtask

  task automatic test_div();
    run_op(OPSEL_DIV, 32'd100, 32'd7, 5, 1'b1, 32'd2, 32'd14);
  endtask

  task automatic test_div_zero();
    run_op(OPSEL_DIV, 32'd7, 32'd0, 0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_timeout();
    run_op(OPSEL_MULT, 32'h10, 32'h20, 0, 1'b0, 32'd0, 32'd0);
    run_op(OPSEL_MULT, 32'h10, 32'h20, 4, 1'b1, 32'd0, 32'h200);
    run_op(OPSEL_DIV, 32'd50, 32'd3, 0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_reset_mid_op();
    step();
    SrcA = 32'd9; SrcB = 32'd4; OpSel = OPSEL_MULT; OpStart = 1'b1;
    step();
    OpStart = 1'b0;
    repeat (11) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    @(negedge Clock);
    checks++;
    if ({Busy, MultStart, Done, Timeout, HI, LO} !== 68'd0) begin
      fails++;
      $display("FAIL reset_mid_op: got busy=%b ms=%b done=%b tmo=%b hi=%h lo=%h want all zero",
               Busy, MultStart, Done, Timeout, HI, LO);
    end
    step();
    MultStop = 1'b1; MultHI = $urandom; MultLO = $urandom;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      checks++;
      if ({Done, Busy, HI, LO} !== 66'd0) begin
        fails++;
        $display("FAIL late_stop%0d: got done=%b busy=%b hi=%h lo=%h want all zero", k, Done, Busy, HI, LO);
      end
      step();
      MultStop = 1'b0;
    end
  endtask

  task automatic test_random();
    logic        sel;
    logic [31:0] a, b;
    logic [63:0] res;
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        step();
        MTHI = $urandom_range(0, 1); MTLO = $urandom_range(0, 1); WrData = $urandom;
        if (MTHI) exp_hi = WrData;
        if (MTLO) exp_lo = WrData;
        step();
        MTHI = 1'b0; MTLO = 1'b0;
      end
      sel = $urandom_range(0, 1);
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (sel == OPSEL_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      res = (sel == OPSEL_DIV && b == 32'd0) ? 64'd0 : ref_result(sel, a, b);
      run_op(sel, a, b, $urandom_range(1, TO), ($urandom_range(0, 9) != 0), res[63:32], res[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_div_zero();
    test_mult();
    test_div();
    test_timeout();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
